// File: rtl/ee354_gcd_pkg.sv
// Shared definitions for the EE354 GCD datapath: operand width and the
// one-hot state encoding used by the operand loader and the GCD core.
package ee354_gcd_pkg;

  localparam int OPW = 8;

  // One-hot encoding: each state drives its own LED directly.
  typedef enum logic [4:0] {
    ST_EMPTY  = 5'b00001,
    ST_HAVE_A = 5'b00010,
    ST_READY  = 5'b00100,
    ST_BUSY   = 5'b01000,
    ST_RESULT = 5'b10000
  } state_t;

endpackage

// File: rtl/ee354_gcd_operand_loader.sv
// Operand loader for the GCD core: captures A/B from switches on Load, issues
// Start/Ack pulses on Go, and counts cycles spent waiting on the core.
module ee354_gcd_operand_loader
  import ee354_gcd_pkg::*;
#(
  parameter bit ZERO_CHECK = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [OPW-1:0]   Sw,
  input  logic             Go,
  input  logic             Core_Done,
  output logic [OPW-1:0]   Ain,
  output logic [OPW-1:0]   Bin,
  output logic             Start,
  output logic             Ack,
  output logic             Err,
  output logic [CNT_W-1:0] Busy_Cycles,
  output logic             q_Empty,
  output logic             q_HaveA,
  output logic             q_Ready,
  output logic             q_Busy,
  output logic             q_Result
);

  state_t state;
  logic   go_ok;
  logic   zero_op;

  // Load wins over a coincident Go in every state.
  assign go_ok   = Go & ~Load;
  assign zero_op = ZERO_CHECK && ((Ain == '0) || (Bin == '0));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= ST_EMPTY;
      Ain         <= '0;
      Bin         <= '0;
      Start       <= 1'b0;
      Ack         <= 1'b0;
      Err         <= 1'b0;
      Busy_Cycles <= '0;
    end else begin
      Start <= 1'b0;
      Ack   <= 1'b0;
      case (state)
        ST_EMPTY: begin
          if (Load) begin
            Ain   <= Sw;
            Err   <= 1'b0;
            state <= ST_HAVE_A;
          end
        end
        ST_HAVE_A: begin
          if (Load) begin
            Bin   <= Sw;
            Err   <= 1'b0;
            state <= ST_READY;
          end
        end
        ST_READY: begin
          if (Load) begin
            Ain   <= Sw;
            Err   <= 1'b0;
            state <= ST_HAVE_A;
          end else if (go_ok) begin
            if (zero_op) begin
              Err <= 1'b1;
            end else begin
              Err         <= 1'b0;
              Start       <= 1'b1;
              Busy_Cycles <= '0;
              state       <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (Busy_Cycles != '1)
            Busy_Cycles <= Busy_Cycles + 1'b1;
          // Start is high only in the first BUSY cycle; the core can't be done yet.
          if (!Start && Core_Done)
            state <= ST_RESULT;
        end
        ST_RESULT: begin
          if (go_ok) begin
            Ack   <= 1'b1;
            state <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign q_Empty  = (state == ST_EMPTY);
  assign q_HaveA  = (state == ST_HAVE_A);
  assign q_Ready  = (state == ST_READY);
  assign q_Busy   = (state == ST_BUSY);
  assign q_Result = (state == ST_RESULT);

endmodule
